// File: rtl/srl_vec_pkg.sv
// Shared constants and helpers for the variable-tap shift register.
package srl_vec_pkg;

    // Legal parameter ranges for the shift register.
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;
    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 256;

    // Ceiling log2 that never returns less than 1, so the tap address
    // always has at least one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/srl_vec_cnt.sv
// Saturating fill counter with the tap-valid and full flags.
module srl_vec_cnt
    import srl_vec_pkg::*;
#(
    parameter int DEPTH         = 32,
    parameter bit IS_C_INVERTED = 1'b0,
    parameter int AW            = clog2_min1(DEPTH)
) (
    input  logic          C,
    input  logic          CLR_N,
    input  logic          CE,
    input  logic [AW-1:0] A,
    output logic [AW:0]   FILL,
    output logic          VALID,
    output logic          FULL
);

    localparam logic [AW:0] LP_FILL_MAX = (AW+1)'(DEPTH);

    logic [AW:0] r_fill = '0;
    logic [AW:0] w_fill_next;
    logic        w_a_oor;

    // Count one per enabled shift, sticking at DEPTH.
    always_comb begin
        w_fill_next = r_fill;
        if (CE && (r_fill != LP_FILL_MAX)) begin
            w_fill_next = r_fill + 1'b1;
        end
    end

    generate
        if (IS_C_INVERTED) begin : g_fall
            // Falling-edge counter register, cleared asynchronously.
            always_ff @(negedge C or negedge CLR_N) begin
                if (!CLR_N) r_fill <= '0;
                else        r_fill <= w_fill_next;
            end
        end else begin : g_rise
            // Rising-edge counter register, cleared asynchronously.
            always_ff @(posedge C or negedge CLR_N) begin
                if (!CLR_N) r_fill <= '0;
                else        r_fill <= w_fill_next;
            end
        end
    endgenerate

    // Addresses past the last stage alias to the last stage, so their
    // valid flag follows the full flag.
    always_comb begin
        w_a_oor = ({1'b0, A} >= LP_FILL_MAX);
        FULL    = (r_fill == LP_FILL_MAX);
        VALID   = w_a_oor ? FULL : (r_fill > {1'b0, A});
        FILL    = r_fill;
    end

endmodule

// File: rtl/srl_vec.sv
// Variable-tap shift register: DEPTH stages of WIDTH bits, a dynamic
// combinational tap, a cascade output and fill tracking.
module srl_vec
    import srl_vec_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               DEPTH         = 32,
    parameter bit               IS_C_INVERTED = 1'b0,
    parameter logic [WIDTH-1:0] IS_D_INVERTED = '0,
    parameter logic [WIDTH-1:0] INIT          = '0,
    localparam int              AW            = clog2_min1(DEPTH)
) (
    input  logic             C,
    input  logic             CLR_N,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    A,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_LAST,
    output logic [AW:0]      FILL,
    output logic             VALID,
    output logic             FULL
);

    localparam int LP_TAPS = 1 << AW;

    // Declaration initialisers give the power-up state, matching reset.
    logic [WIDTH-1:0] r_stage [DEPTH] = '{default: INIT};
    logic [WIDTH-1:0] w_shift [DEPTH];
    logic [WIDTH-1:0] w_tap   [LP_TAPS];

    // Shifted-by-one view of the stage array, fresh data at stage 0.
    assign w_shift[0] = D ^ IS_D_INVERTED;
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
            assign w_shift[gi] = r_stage[gi-1];
        end
    endgenerate

    generate
        if (IS_C_INVERTED) begin : g_fall
            // Falling-edge stage update; clear loads INIT without a clock.
            always_ff @(negedge C or negedge CLR_N) begin
                if (!CLR_N) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= INIT;
                end else if (CE) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= w_shift[i];
                end
            end
        end else begin : g_rise
            // Rising-edge stage update; clear loads INIT without a clock.
            always_ff @(posedge C or negedge CLR_N) begin
                if (!CLR_N) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= INIT;
                end else if (CE) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= w_shift[i];
                end
            end
        end
    endgenerate

    // Pad the tap table to a power of two; unused addresses show the
    // last stage so out-of-range taps match the cascade output.
    generate
        for (genvar gi = 0; gi < LP_TAPS; gi++) begin : g_tap
            if (gi < DEPTH) begin : g_real
                assign w_tap[gi] = r_stage[gi];
            end else begin : g_alias
                assign w_tap[gi] = r_stage[DEPTH-1];
            end
        end
    endgenerate

    assign Q      = w_tap[A];
    assign Q_LAST = r_stage[DEPTH-1];

    srl_vec_cnt #(
        .DEPTH         (DEPTH),
        .IS_C_INVERTED (IS_C_INVERTED),
        .AW            (AW)
    ) u_cnt (
        .C     (C),
        .CLR_N (CLR_N),
        .CE    (CE),
        .A     (A),
        .FILL  (FILL),
        .VALID (VALID),
        .FULL  (FULL)
    );

endmodule

// File: tb/tb_srl_vec.sv
// Directed bench for srl_vec: three configurations driven in sequence.
module tb_srl_vec;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Config 0: WIDTH=8, DEPTH=4, INIT=A5, rising edge.
    logic       clr0 = 1'b1, ce0 = 1'b0;
    logic [7:0] d0 = '0;
    logic [1:0] a0 = '0;
    logic [7:0] q0, ql0;
    logic [2:0] fill0;
    logic       valid0, full0;

    // Config 1: falling edge, D inversion mask 0F.
    logic       clr1 = 1'b0, ce1 = 1'b0;
    logic [7:0] d1 = '0;
    logic [1:0] a1 = '0;
    logic [7:0] q1, ql1;
    logic [2:0] fill1;
    logic       valid1, full1;

    // Config 2: WIDTH=1, DEPTH=5, tap parked out of range.
    logic       clr2 = 1'b0, ce2 = 1'b0;
    logic [0:0] d2 = '0;
    logic [2:0] a2 = 3'd7;
    logic [0:0] q2, ql2;
    logic [3:0] fill2;
    logic       valid2, full2;

    srl_vec #(.WIDTH(8), .DEPTH(4), .INIT(8'hA5)) u0 (
        .C(clk), .CLR_N(clr0), .CE(ce0), .D(d0), .A(a0),
        .Q(q0), .Q_LAST(ql0), .FILL(fill0), .VALID(valid0), .FULL(full0));

    srl_vec #(.WIDTH(8), .DEPTH(4), .IS_C_INVERTED(1'b1),
              .IS_D_INVERTED(8'h0F), .INIT(8'h00)) u1 (
        .C(clk), .CLR_N(clr1), .CE(ce1), .D(d1), .A(a1),
        .Q(q1), .Q_LAST(ql1), .FILL(fill1), .VALID(valid1), .FULL(full1));

    srl_vec #(.WIDTH(1), .DEPTH(5), .INIT(1'b0)) u2 (
        .C(clk), .CLR_N(clr2), .CE(ce2), .D(d2), .A(a2),
        .Q(q2), .Q_LAST(ql2), .FILL(fill2), .VALID(valid2), .FULL(full2));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_q3 [4];
    logic [0:0] exp_last2 [6];

    initial begin
        exp_q3    = '{8'hA5, 8'hA5, 8'hA5, 8'h01};
        exp_last2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Power-up state equals the reset state.
        #1;
        check("pwrup_qlast", 64'(ql0), 64'hA5);
        check("pwrup_fill",  64'(fill0), 64'd0);

        // Reset held across an enabled edge: nothing moves.
        clr0 = 1'b0; ce0 = 1'b1; d0 = 8'h77; a0 = 2'd3;
        tick();
        check("rst_q",     64'(q0), 64'hA5);
        check("rst_qlast", 64'(ql0), 64'hA5);
        check("rst_fill",  64'(fill0), 64'd0);
        check("rst_valid", 64'(valid0), 64'd0);
        check("rst_full",  64'(full0), 64'd0);

        // Fill with 01..04, tap at stage 3.
        clr0 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            d0 = 8'(k);
            tick();
            $display("fill edge %0d: D=%0h Q=%0h FILL=%0d VALID=%0b FULL=%0b", k, d0, q0, fill0, valid0, full0);
            check($sformatf("fill%0d_fill", k),  64'(fill0), 64'(k));
            check($sformatf("fill%0d_q3", k),    64'(q0), 64'(exp_q3[k-1]));
            check($sformatf("fill%0d_valid", k), 64'(valid0), (k == 4) ? 64'd1 : 64'd0);
            check($sformatf("fill%0d_full", k),  64'(full0),  (k == 4) ? 64'd1 : 64'd0);
        end
        check("full_qlast", 64'(ql0), 64'h01);
        a0 = 2'd0; #1;
        check("tap0_q", 64'(q0), 64'h04);
        a0 = 2'd1; #1;
        check("tap1_q", 64'(q0), 64'h03);

        // Saturation: three more shifts.
        for (int k = 5; k <= 7; k++) begin
            d0 = 8'(k);
            tick();
            $display("sat edge: D=%0h QLAST=%0h FILL=%0d", d0, ql0, fill0);
            check("sat_fill", 64'(fill0), 64'd4);
        end
        check("sat_qlast", 64'(ql0), 64'h04);
        a0 = 2'd0; #1;
        check("sat_q0", 64'(q0), 64'h07);

        // Hold: CE low for five edges.
        ce0 = 1'b0; d0 = 8'hFF;
        for (int k = 0; k < 5; k++) tick();
        check("hold_qlast", 64'(ql0), 64'h04);
        check("hold_q0",    64'(q0), 64'h07);
        check("hold_fill",  64'(fill0), 64'd4);

        // One more shift, then a 1 ns clear pulse between edges.
        ce0 = 1'b1; d0 = 8'h08;
        tick();
        check("pre_clr_q0", 64'(q0), 64'h08);
        #2 clr0 = 1'b0;
        #1;
        check("clr_qlast", 64'(ql0), 64'hA5);
        check("clr_q0",    64'(q0), 64'hA5);
        check("clr_fill",  64'(fill0), 64'd0);
        check("clr_valid", 64'(valid0), 64'd0);
        check("clr_full",  64'(full0), 64'd0);
        clr0 = 1'b1;

        // Clear held over an edge, then first shift after release.
        tick();
        clr0 = 1'b0; d0 = 8'h99;
        tick();
        check("clr_edge_q0",   64'(q0), 64'hA5);
        check("clr_edge_fill", 64'(fill0), 64'd0);
        clr0 = 1'b1; d0 = 8'h11;
        tick();
        check("rel_q0",    64'(q0), 64'h11);
        check("rel_fill",  64'(fill0), 64'd1);
        check("rel_qlast", 64'(ql0), 64'hA5);
        ce0 = 1'b0;

        // Falling-edge config with D inversion.
        ce1 = 1'b1; d1 = 8'h00; a1 = 2'd0;
        @(negedge clk); #1;
        clr1 = 1'b1;
        @(posedge clk); #1;
        check("inv_rise_q",    64'(q1), 64'h00);
        check("inv_rise_fill", 64'(fill1), 64'd0);
        @(negedge clk); #1;
        $display("inv fall edge: D=%0h Q=%0h FILL=%0d", d1, q1, fill1);
        check("inv_fall_q",    64'(q1), 64'h0F);
        check("inv_fall_fill", 64'(fill1), 64'd1);
        d1 = 8'hF0;
        @(posedge clk); #1;
        check("inv_rise2_q", 64'(q1), 64'h0F);
        @(negedge clk); #1;
        check("inv_fall2_q", 64'(q1), 64'hFF);
        a1 = 2'd1; #1;
        check("inv_tap1_q", 64'(q1), 64'h0F);
        ce1 = 1'b0;

        // DEPTH=5 with out-of-range tap: Q follows Q_LAST, VALID follows FULL.
        clr2 = 1'b1; ce2 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            d2 = (k == 1) ? 1'b1 : 1'b0;
            tick();
            $display("d5 edge %0d: D=%0b Q=%0b QLAST=%0b VALID=%0b FULL=%0b FILL=%0d", k, d2, q2, ql2, valid2, full2, fill2);
            check($sformatf("d5_%0d_qlast", k), 64'(ql2), 64'(exp_last2[k-1]));
            check($sformatf("d5_%0d_q", k),     64'(q2),  64'(exp_last2[k-1]));
            check($sformatf("d5_%0d_valid", k), 64'(valid2), (k >= 5) ? 64'd1 : 64'd0);
            check($sformatf("d5_%0d_full", k),  64'(full2),  (k >= 5) ? 64'd1 : 64'd0);
        end
        check("d5_fill_sat", 64'(fill2), 64'd5);
        a2 = 3'd4; #1;
        check("d5_tap4_q", 64'(q2), 64'd0);
        a2 = 3'd3; #1;
        check("d5_tap3_q", 64'(q2), 64'd0);
        a2 = 3'd0; #1;
        check("d5_tap0_q", 64'(q2), 64'd0);
        ce2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/srl_vec.md
SRL_VEC -- requirements
Module: srl_vec

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data bits per stage (1..64).
REQ-002 SHALL have parameter DEPTH, default 32, number of shift stages (2..256).
REQ-003 SHALL have parameter IS_C_INVERTED, default 1'b0, selects falling-edge clocking when 1.
REQ-004 SHALL have parameter IS_D_INVERTED, default all-zero [WIDTH-1:0], per-bit inversion of D before capture.
REQ-005 SHALL have parameter INIT, default all-zero [WIDTH-1:0], value loaded into every stage at power-up and reset.
REQ-006 SHALL derive localparam AW = clog2(DEPTH), minimum 1.
REQ-007 SHALL have port C, input, 1, clock; active edge per IS_C_INVERTED.
REQ-008 SHALL have port CLR_N, input, 1; one clock, reset asynchronous and active-low.
REQ-009 SHALL have port CE, input, 1, shift enable.
REQ-010 SHALL have port D, input, WIDTH, data into stage 0.
REQ-011 SHALL have port A, input, AW, dynamic tap address.
REQ-012 SHALL have port Q, output, WIDTH, contents of stage A.
REQ-013 SHALL have port Q_LAST, output, WIDTH, contents of stage DEPTH-1 (cascade output).
REQ-014 SHALL have port FILL, output, AW+1, number of valid stages, saturating at DEPTH.
REQ-015 SHALL have port VALID, output, 1, high when stage A holds shifted-in data.
REQ-016 SHALL have port FULL, output, 1, high when FILL == DEPTH.

Function
REQ-017 On each active C edge with CLR_N=1 and CE=1: stage[0] <= D ^ IS_D_INVERTED; stage[i] <= stage[i-1] for i = 1..DEPTH-1.
REQ-018 With CE=0 on an active edge, all stages and FILL SHALL hold.
REQ-019 Q SHALL be combinational from A and the stages (zero-cycle address-to-output); a write becomes visible on Q after the same edge.
REQ-020 If A >= DEPTH (non-power-of-2 DEPTH), Q SHALL equal Q_LAST and VALID SHALL equal FULL.
REQ-021 FILL SHALL increment by 1 per enabled shift and saturate at DEPTH; no wrap-around.
REQ-022 VALID SHALL equal (FILL > A), combinational.
REQ-023 FULL SHALL equal (FILL == DEPTH), combinational.
REQ-024 Data latency D -> Q SHALL be A+1 enabled shifts; D -> Q_LAST SHALL be DEPTH enabled shifts.
REQ-025 Change of A while CE=1 SHALL NOT alter stage contents; it affects only Q and VALID.

Reset
REQ-026 CLR_N=0 SHALL immediately, without a clock edge, set every stage to INIT and FILL to 0; Q=Q_LAST=INIT, VALID=0, FULL=0.
REQ-027 While CLR_N=0, active edges SHALL be ignored regardless of CE.
REQ-028 Assertion of CLR_N mid-stream SHALL discard all contents; the first shift after release SHALL occur on the first active edge with CLR_N=1 and CE=1.
REQ-029 Power-up state, before any reset, SHALL equal the reset state.

Structure
REQ-030 Package srl_vec_pkg SHALL hold the clog2-with-minimum-1 function and the DEPTH/WIDTH limit constants.
REQ-031 The saturating FILL counter with VALID/FULL compare SHALL be sub-module srl_vec_cnt; the stage array and tap mux stay in srl_vec.
REQ-032 Clock-edge selection SHALL be a generate branch on IS_C_INVERTED; no gated or XORed clock.

Verification
REQ-033 WIDTH=8, DEPTH=4, INIT=8'hA5; reset, then CE=1 with D=01,02,03,04 -> after edges 1-4 FILL=1..4, FULL after edge 4, Q_LAST=01 after edge 4, A=0 gives Q=04.
REQ-034 Same config after reset with A=3: Q=A5 and VALID=0 until the 4th shift; then Q=01 and VALID=1.
REQ-035 Fill to FULL, 3 more shifts (05,06,07) -> FILL stays 4, Q_LAST=04; CE=0 for 5 edges -> no change.
REQ-036 Mid-stream CLR_N pulse of 1 ns between edges -> all stages A5, FILL=0 immediately; an edge during the low pulse is ignored.
REQ-037 IS_C_INVERTED=1, IS_D_INVERTED=8'h0F, D=8'h00 -> captured on falling edge as 8'h0F; rising edges do nothing.
REQ-038 DEPTH=5, WIDTH=1, A=7 -> Q tracks Q_LAST and VALID tracks FULL through fill.
